// File: rtl/seg7_hex_reader_pkg.sv
// ----------------------------------------------------------------------------
// seg7_hex_reader_pkg
//   Shared definitions for the 7-segment HEX reader.
//   - Glyph constants SEG_0..SEG_F and SEG_BLANK, active-high, bit order {g,f,e,d,c,b,a}.
//     The display encoder that drives the HEX bus uses the same constants,
//     so encoder and reader cannot drift apart.
//   - SEG_SENTINEL: raw value loaded into the sample registers at reset.
//   - seg7_dec_t: result of decoding one pattern.
// ----------------------------------------------------------------------------
package seg7_hex_reader_pkg;

   localparam logic [6:0] SEG_0        = 7'h3F;
   localparam logic [6:0] SEG_1        = 7'h06;
   localparam logic [6:0] SEG_2        = 7'h5B;
   localparam logic [6:0] SEG_3        = 7'h4F;
   localparam logic [6:0] SEG_4        = 7'h66;
   localparam logic [6:0] SEG_5        = 7'h6D;
   localparam logic [6:0] SEG_6        = 7'h7D;
   localparam logic [6:0] SEG_7        = 7'h07;
   localparam logic [6:0] SEG_8        = 7'h7F;
   localparam logic [6:0] SEG_9        = 7'h6F;
   localparam logic [6:0] SEG_A        = 7'h77;
   localparam logic [6:0] SEG_B        = 7'h7C;  // lower-case b
   localparam logic [6:0] SEG_C        = 7'h39;
   localparam logic [6:0] SEG_D        = 7'h5E;  // lower-case d
   localparam logic [6:0] SEG_E        = 7'h79;
   localparam logic [6:0] SEG_F        = 7'h71;
   localparam logic [6:0] SEG_BLANK    = 7'h00;

   localparam logic [6:0] SEG_SENTINEL = 7'h7F;

   typedef struct packed {
      logic       legal;  // pattern is one of the 16 hex glyphs
      logic       blank;  // pattern has every segment off
      logic [3:0] digit;  // hex value, meaningful only when legal
   } seg7_dec_t;

endpackage

// File: rtl/seg7_to_hex.sv
// ----------------------------------------------------------------------------
// seg7_to_hex
//   Combinational decoder: active-high 7-segment pattern -> {legal, blank, digit}.
//   Ports:
//     i_seg  in  7   pattern {g,f,e,d,c,b,a}, 1 = segment lit
//     o_dec  out     decode result; legal and blank are never both set
// ----------------------------------------------------------------------------
module seg7_to_hex
   import seg7_hex_reader_pkg::*;
(
   input  logic [6:0] i_seg,
   output seg7_dec_t  o_dec
);

   always_comb begin
      o_dec.legal = 1'b1;
      o_dec.blank = 1'b0;
      o_dec.digit = 4'h0;
      case (i_seg)
         SEG_0:     o_dec.digit = 4'h0;
         SEG_1:     o_dec.digit = 4'h1;
         SEG_2:     o_dec.digit = 4'h2;
         SEG_3:     o_dec.digit = 4'h3;
         SEG_4:     o_dec.digit = 4'h4;
         SEG_5:     o_dec.digit = 4'h5;
         SEG_6:     o_dec.digit = 4'h6;
         SEG_7:     o_dec.digit = 4'h7;
         SEG_8:     o_dec.digit = 4'h8;
         SEG_9:     o_dec.digit = 4'h9;
         SEG_A:     o_dec.digit = 4'hA;
         SEG_B:     o_dec.digit = 4'hB;
         SEG_C:     o_dec.digit = 4'hC;
         SEG_D:     o_dec.digit = 4'hD;
         SEG_E:     o_dec.digit = 4'hE;
         SEG_F:     o_dec.digit = 4'hF;
         SEG_BLANK: begin
            o_dec.legal = 1'b0;
            o_dec.blank = 1'b1;
         end
         default:   o_dec.legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_hex_reader.sv
// ----------------------------------------------------------------------------
// seg7_hex_reader
//   Samples a 7-segment HEX bus, waits until the pattern has been stable for
//   STABLE_CYCLES samples, decodes it and hands the value out on valid/ready.
//   Blank patterns set o_blank, illegal patterns pulse o_err and bump a
//   saturating error counter; overwriting an unconsumed value sets o_ovr.
//   Parameters:
//     STABLE_CYCLES  identical samples needed before a pattern is accepted (>=1)
//     ACTIVE_LOW     1: segment lit when bus bit is 0
//     CNT_W          width of o_err_cnt
//   Ports:
//     i_clk      clock, everything on the rising edge
//     i_rst_n    synchronous active-low reset
//     i_HEX      segment bus {g,f,e,d,c,b,a}
//     i_ready    consumer takes o_digit when o_valid & i_ready
//     i_clr      clears o_err_cnt and o_ovr (wins over same-cycle events)
//     o_digit    last accepted hex value
//     o_valid    o_digit not yet consumed
//     o_blank    last accepted pattern was all-off
//     o_err      one-cycle pulse for an accepted illegal pattern
//     o_err_cnt  saturating count of o_err pulses
//     o_ovr      sticky overrun flag
// ----------------------------------------------------------------------------
module seg7_hex_reader
   import seg7_hex_reader_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int CNT_W         = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [6:0]       i_HEX,
   input  logic             i_ready,
   input  logic             i_clr,
   output logic [3:0]       o_digit,
   output logic             o_valid,
   output logic             o_blank,
   output logic             o_err,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic             o_ovr
);

   localparam int               STB_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] ERR_MAX = '1;

   // Two-stage raw sampling: r_in is the newest sample, r_last the one
   // before it. Comparing these two (rather than i_HEX directly) puts the
   // accept exactly STABLE_CYCLES edges after the first sample of a pattern.
   logic [6:0]       r_in;
   logic [6:0]       r_last;
   logic             r_in_vld;   // r_in holds a real sample, not the sentinel
   logic [STB_W-1:0] r_stb;
   logic             r_armed;

   logic [3:0]       r_digit;
   logic             r_valid;
   logic             r_blank;
   logic             r_err;
   logic [CNT_W-1:0] r_err_cnt;
   logic             r_ovr;

   logic [6:0]       w_norm;
   seg7_dec_t        w_dec;
   logic             w_change;
   logic             w_arm_cur;
   logic [STB_W-1:0] w_stb_next;
   logic             w_accept;
   logic             w_legal_acc;
   logic             w_blank_acc;
   logic             w_err_acc;
   logic             w_xfer;

   // Polarity fix: the decoder always sees active-high segments.
   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_norm
         assign w_norm[gi] = ACTIVE_LOW ? ~r_in[gi] : r_in[gi];
      end
   endgenerate

   seg7_to_hex u_dec (
      .i_seg (w_norm),
      .o_dec (w_dec)
   );

   // Stability counter and arm flag. The accept is qualified on the next
   // counter value so that it fires on the very edge the count reaches
   // STABLE_CYCLES; the arm flag then blocks repeats until a change.
   always_comb begin
      w_change   = (r_in != r_last);
      w_stb_next = r_stb;
      w_arm_cur  = r_armed;
      if (r_in_vld) begin
         if (w_change) begin
            w_stb_next = STB_W'(1);
            w_arm_cur  = 1'b1;
         end else if (r_stb != STB_MAX) begin
            w_stb_next = r_stb + STB_W'(1);
         end
      end
      w_accept = r_in_vld && w_arm_cur && (w_stb_next == STB_MAX);
   end

   assign w_legal_acc = w_accept &  w_dec.legal;
   assign w_blank_acc = w_accept &  w_dec.blank;
   assign w_err_acc   = w_accept & ~w_dec.legal & ~w_dec.blank;
   assign w_xfer      = r_valid & i_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_in      <= SEG_SENTINEL;
         r_last    <= SEG_SENTINEL;
         r_in_vld  <= 1'b0;
         r_stb     <= '0;
         r_armed   <= 1'b1;
         r_digit   <= '0;
         r_valid   <= 1'b0;
         r_blank   <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
         r_ovr     <= 1'b0;
      end else begin
         r_in     <= i_HEX;
         r_last   <= r_in;
         r_in_vld <= 1'b1;
         r_stb    <= w_stb_next;
         r_armed  <= w_arm_cur & ~w_accept;

         // A legal accept always leaves o_valid set, even when the old
         // value is transferred on the same edge.
         if (w_legal_acc) begin
            r_digit <= w_dec.digit;
            r_valid <= 1'b1;
            r_blank <= 1'b0;
         end else begin
            if (w_xfer) begin
               r_valid <= 1'b0;
            end
            if (w_blank_acc) begin
               r_blank <= 1'b1;
            end
         end

         r_err <= w_err_acc;

         if (i_clr) begin
            r_err_cnt <= '0;
            r_ovr     <= 1'b0;
         end else begin
            if (w_err_acc && (r_err_cnt != ERR_MAX)) begin
               r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_legal_acc && r_valid && !w_xfer) begin
               r_ovr <= 1'b1;
            end
         end
      end
   end

   assign o_digit   = r_digit;
   assign o_valid   = r_valid;
   assign o_blank   = r_blank;
   assign o_err     = r_err;
   assign o_err_cnt = r_err_cnt;
   assign o_ovr     = r_ovr;

endmodule
